// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequenced execute ALU: the fixed opcode
// encoding, the control state encoding and a helper that tells the
// control path which opcodes go through the iterative mul/div unit.
// No ports; imported by alu_seq, alu_muldiv_iter and the bench.
package alu_seq_pkg;

    typedef enum logic [4:0] {
        OP_NOP    = 5'd0,
        OP_ADD    = 5'd1,
        OP_SUB    = 5'd2,
        OP_XOR    = 5'd3,
        OP_OR     = 5'd4,
        OP_AND    = 5'd5,
        OP_SLL    = 5'd6,
        OP_SRL    = 5'd7,
        OP_SRA    = 5'd8,
        OP_SLT    = 5'd9,
        OP_SLTU   = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18,
        OP_LUI    = 5'd28,
        OP_AUIPC  = 5'd29
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // MUL through REMU form one contiguous opcode range
    function automatic logic is_multicycle(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if
// Bundles the issue side (in_*), writeback side (out_*, rd_*), the
// flush request and the busy status of the sequenced ALU.
//   master : the pipeline (drives operation, operands, out_ready, flush)
//   slave  : the ALU (drives in_ready, out_valid, rd_*, busy)
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_control;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic            rd_write_control;
    logic [XLEN-1:0] rd_write_val;
    logic            busy;

    modport master (
        output flush, in_valid, alu_control, pc, imm, rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, rd_write_control, rd_write_val, busy
    );

    modport slave (
        input  flush, in_valid, alu_control, pc, imm, rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, rd_write_control, rd_write_val, busy
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter
// Iterative radix-2 multiply/divide unit. Operands are converted to
// magnitudes at start, a shift-add multiplier or restoring divider runs
// for exactly XLEN steps in one shared 2*XLEN accumulator, and signs and
// divide-by-zero are fixed up on the final step.
//   clk, rst      : clock, async active-high reset
//   abort         : drop the operation in flight
//   start         : load op/rs1/rs2 and begin (ignored while aborting)
//   op, rs1, rs2  : MUL..REMU opcode and operands
//   busy          : stepping in progress
//   done          : one-cycle pulse on the last step, result valid with it
//   result        : sign-corrected result, meaningful while done is high
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   rs1_q;
    logic [4:0]        op_q;
    logic [CW-1:0]     count;
    logic              running;
    logic              is_div_q;
    logic              neg_main;
    logic              neg_rem;
    logic              div_zero;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_tmp;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // Operand preparation: which operands are signed for this opcode and
    // their magnitudes, so the datapath itself is purely unsigned.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg = a_signed & rs1[XLEN-1];
        b_neg = b_signed & rs2[XLEN-1];
        a_abs = a_neg ? -rs1 : rs1;
        b_abs = b_neg ? -rs2 : rs2;
    end

    // One radix-2 step. Multiply: add the multiplicand into the upper half
    // when the low bit is set, then shift right. Divide: shift the
    // remainder:dividend pair left and subtract the divisor if it fits,
    // shifting the quotient bit in at the bottom.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
        div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_tmp - {1'b0, divisor};
        if (is_div_q) begin
            if (div_diff[XLEN])
                acc_next = {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign correction on the final step. Signed overflow (most negative
    // divided by -1) falls out naturally: magnitude 2^(XLEN-1) with no
    // negation gives back rs1, remainder 0. Divide by zero is forced here.
    always_comb begin
        prod_fix = neg_main ? -acc_next : acc_next;
        quot_fix = neg_main ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix  = neg_rem  ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        result   = '0;
        case (op_q)
            OP_MUL:                       result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = div_zero ? '1 : quot_fix;
            OP_REM, OP_REMU:              result = div_zero ? rs1_q : rem_fix;
            default:                      result = '0;
        endcase
    end

    assign done = running && (count == CW'(XLEN - 1));
    assign busy = running;

    // Step register: load on start, step every cycle while running, stop
    // after the XLEN-th step or on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running  <= 1'b0;
            count    <= '0;
            acc      <= '0;
            divisor  <= '0;
            rs1_q    <= '0;
            op_q     <= '0;
            is_div_q <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running  <= 1'b1;
            count    <= '0;
            acc      <= {{XLEN{1'b0}}, a_abs};
            divisor  <= b_abs;
            rs1_q    <= rs1;
            op_q     <= op;
            is_div_q <= (op >= OP_DIV);
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (rs2 == '0);
        end else if (running) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (done)
                running <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Handshaked execute ALU. Single-cycle opcodes are registered straight
// into the result; MUL/DIV/REM are handed to alu_muldiv_iter and the
// block stalls (in_ready low) until the fixed-latency result returns.
//   clk, rst : clock, async active-high reset
//   bus      : alu_seq_if slave (issue/writeback handshakes, flush, busy)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    alu_state_e      state, state_next;
    logic            accept;
    logic            start_md;
    logic            load_single;
    logic            load_md;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] single_val;
    logic            single_wc;
    logic [XLEN-1:0] rd_val_q;
    logic            rd_wc_q;
    logic [SHW-1:0]  shamt;

    assign bus.in_ready         = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept               = bus.in_valid && bus.in_ready && !bus.flush;
    assign bus.out_valid        = (state == DONE);
    assign bus.busy             = (state == BUSY);
    assign bus.rd_write_val     = rd_val_q;
    assign bus.rd_write_control = rd_wc_q;
    assign shamt                = bus.rs2_val[SHW-1:0];

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .abort  (bus.flush),
        .start  (start_md),
        .op     (bus.alu_control),
        .rs1    (bus.rs1_val),
        .rs2    (bus.rs2_val),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Single-cycle result; NOP and unassigned opcodes write nothing.
    always_comb begin
        single_val = '0;
        single_wc  = 1'b1;
        case (bus.alu_control)
            OP_ADD:   single_val = bus.rs1_val + bus.rs2_val;
            OP_SUB:   single_val = bus.rs1_val - bus.rs2_val;
            OP_XOR:   single_val = bus.rs1_val ^ bus.rs2_val;
            OP_OR:    single_val = bus.rs1_val | bus.rs2_val;
            OP_AND:   single_val = bus.rs1_val & bus.rs2_val;
            OP_SLL:   single_val = bus.rs1_val << shamt;
            OP_SRL:   single_val = bus.rs1_val >> shamt;
            OP_SRA:   single_val = $signed(bus.rs1_val) >>> shamt;
            OP_SLT:   single_val = {{(XLEN-1){1'b0}}, $signed(bus.rs1_val) < $signed(bus.rs2_val)};
            OP_SLTU:  single_val = {{(XLEN-1){1'b0}}, bus.rs1_val < bus.rs2_val};
            OP_LUI:   single_val = bus.imm;
            OP_AUIPC: single_val = bus.pc + bus.imm;
            default:  single_wc  = 1'b0;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and load strobes. A new accept in DONE behaves exactly as
    // in IDLE, which is what gives back-to-back single-cycle throughput.
    // Flush overrides everything, including a same-cycle accept.
    always_comb begin
        state_next  = state;
        start_md    = 1'b0;
        load_single = 1'b0;
        load_md     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (state == DONE && bus.out_ready)
                    state_next = IDLE;
                if (accept) begin
                    if (is_multicycle(bus.alu_control)) begin
                        state_next = BUSY;
                        start_md   = 1'b1;
                    end else begin
                        state_next  = DONE;
                        load_single = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_next = DONE;
                    load_md    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next  = IDLE;
            start_md    = 1'b0;
            load_single = 1'b0;
            load_md     = 1'b0;
        end
    end

    // Result register; holds its value while waiting for out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_val_q <= '0;
            rd_wc_q  <= 1'b0;
        end else if (load_single) begin
            rd_val_q <= single_val;
            rd_wc_q  <= single_wc;
        end else if (load_md) begin
            rd_val_q <= md_result;
            rd_wc_q  <= 1'b1;
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle execute ALU. It adds SLT/SLTU, LUI/AUIPC and the RV32M/RV64M multiply/divide set, with an iterative multi-cycle datapath for MUL/DIV/REM. It sits between decode/register-read and writeback, with valid/ready on both sides, so the pipeline stalls while a long operation is in flight.

## Interface
- XLEN, 32 — datapath width; 32 or 64.
- SHW, $clog2(XLEN) — shift-amount width; derived, not overridden.
- clk  in  1  — clock.
- rst  in  1  — asynchronous, active-high reset.
- flush  in  1  — synchronous abort of any in-flight or held result.
- in_valid  in  1  — operation presented.
- in_ready  out  1  — block can accept an operation this cycle.
- alu_control  in  5  — opcode; see Operation.
- pc, imm, rs1_val, rs2_val  in  XLEN each — operands.
- out_valid  out  1  — result held and valid.
- out_ready  in  1  — writeback consumes the result.
- rd_write_control  out  1  — destination write enable accompanying the result.
- rd_write_val  out  XLEN  — result.
- busy  out  1  — iterative operation in progress.

## Operation
Opcode encoding (fixed):
- 0 NOP
- 1 ADD, 2 SUB, 3 XOR, 4 OR, 5 AND
- 6 SLL, 7 SRL, 8 SRA
- 9 SLT, 10 SLTU
- 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU
- 15 DIV, 16 DIVU, 17 REM, 18 REMU
- 28 LUI (result = imm), 29 AUIPC (pc+imm)
- All other opcodes behave as NOP.

Result rules:
- Shifts use rs2_val[SHW-1:0] only; SRA is arithmetic.
- All arithmetic wraps modulo 2^XLEN.
- NOP: rd_write_control=0, rd_write_val=0. Every other opcode: rd_write_control=1.
- Divide by zero: DIV/DIVU return all-ones; REM/REMU return rs1_val.
- Signed overflow (DIV of most-negative value by −1): quotient = rs1_val, remainder = 0.

State machine:
- IDLE
  - Accept (in_valid && in_ready) of a single-cycle opcode → DONE, with the result registered.
  - Accept of opcodes 11–18 → BUSY, loading the sub-module.
- BUSY
  - One radix-2 step per cycle for exactly XLEN cycles, then → DONE.
  - Special cases are resolved at completion, so latency stays fixed.
- DONE
  - Hold the result until out_ready.
  - out_ready with no new accept → IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new accept in DONE follows the IDLE transitions in the same cycle, giving back-to-back throughput for single-cycle ops.
- flush: next state IDLE; the held result is dropped and out_valid is 0 the following cycle. flush wins over a simultaneous accept (the operation is not taken).

## Timing
- Reset values: state IDLE; out_valid=0, rd_write_control=0, rd_write_val=0, busy=0. in_ready=1 from the first cycle after rst deasserts.
- rst asserted mid-BUSY aborts immediately and asynchronously; no result is produced.
- Single-cycle op accepted in cycle N → out_valid in N+1.
- MUL/DIV op accepted in cycle N → busy in N+1..N+XLEN, out_valid in N+XLEN+1.
- Outputs come from registers only; no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready (DONE state only).
- rd_write_val and rd_write_control are stable while out_valid && !out_ready.

## Structure
- Package alu_seq_pkg holds:
  - the opcode enum alu_op_e (values above);
  - the state enum {IDLE, BUSY, DONE};
  - an is_multicycle() function.
- Sub-module alu_muldiv_iter (parameter XLEN) contains:
  - a shift-add multiplier and a restoring divider sharing one 2·XLEN accumulator;
  - a sign-correction stage;
  - start/done pulses and a step counter 0..XLEN−1.

## Test plan
XLEN=32 unless stated.
- Reset:
  - rst pulse mid-BUSY → out_valid and busy drop to 0 without waiting for a clock edge;
  - in_ready=1 on the first post-reset cycle;
  - no spurious result.
- Single-cycle ops:
  - ADD 0xFFFFFFFF+1 → 0, out_valid one cycle after accept;
  - SRA 0x80000000 by rs2=0x21 → 0xC0000000 (only 5 bits of the shift amount used);
  - SLT −1,1 → 1; SLTU −1,1 → 0;
  - AUIPC pc=0x1000, imm=0x2000 → 0x3000;
  - NOP → rd_write_control=0.
- Multiply:
  - MULH 0x80000000×0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE;
  - out_valid exactly 33 cycles after accept.
- Divide corner cases:
  - DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7;
  - DIV 0x80000000/−1 → 0x80000000; REM of the same operands → 0;
  - DIV −7/2 → −3; REM −7/2 → −1.
- Backpressure:
  - hold out_ready=0 for 5 cycles after a result → output stable, in_ready=0;
  - with out_ready=1 and a continuous stream of ADDs → one result per cycle.
- Flush:
  - flush during BUSY, then ADD 2+3 → only 5 is emitted;
  - flush in the same cycle as in_valid → operation not taken.
- XLEN=64 regression: DIVU 2^64−1 / 3 → 0x5555555555555555, latency 65 cycles.
